ts_qos_selector: RTL

TS_QOS_SELECTOR -- requirements
Module: ts_qos_selector

---
 rtl/ts_qos_selector_if.sv | 11 +
 rtl/ts_qos_selector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ts_qos_selector_if.sv
// Memory-mapped register bus between a host (master) and ts_qos_selector (slave).
interface ts_qos_selector_if;
  logic        mm_write_en;
  logic        mm_read_en;
  logic [7:0]  mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;

  modport master (output mm_write_en, mm_read_en, mm_addr, mm_wdata, input mm_rdata);
  modport slave  (input mm_write_en, mm_read_en, mm_addr, mm_wdata, output mm_rdata);
endinterface

// File: rtl/ts_qos_selector.sv
// TS input selector: picks the best locked channel by priority, with hold-off and fallback.
// Optional build macro TS_QOS_ERR_SAT_EN makes the per-channel error counters saturate.
module ts_qos_selector #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = $clog2(NUM_CH),
  parameter int CNT_W     = 8,
  parameter int TIMER_W   = 20,
  parameter int DEF_TIMER = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ch_lock,
  input  logic [NUM_CH-1:0]   ch_err,
  ts_qos_selector_if.slave    mm,
  output logic [CH_W-1:0]     active_ch,
  output logic                sel_valid,
  output logic                switch_pulse
);
  localparam int PW = NUM_CH * CH_W;

  typedef enum logic [1:0] {
    S_NOSIG   = 2'd0,
    S_ACTIVE  = 2'd1,
    S_HOLDOFF = 2'd2,
    S_MANUAL  = 2'd3
  } state_t;

  function automatic logic [PW-1:0] prio_identity();
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      r[k*CH_W +: CH_W] = CH_W'(k);
    end
    return r;
  endfunction

  localparam logic [PW-1:0] PRIO_RST = prio_identity();

  // Returns {found, channel}: lowest-rank locked entry, optionally skipping one channel.
  function automatic logic [CH_W:0] pick(input logic [PW-1:0]     pr,
                                         input logic [NUM_CH-1:0] lk,
                                         input logic              ex_en,
                                         input logic [CH_W-1:0]   ex);
    logic            found;
    logic            hit;
    logic [CH_W-1:0] ch;
    logic [CH_W-1:0] e;
    found = 1'b0;
    ch    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      e     = pr[k*CH_W +: CH_W];
      hit   = !found && (int'(e) < NUM_CH) && lk[e] && !(ex_en && (e == ex));
      ch    = hit ? e : ch;
      found = found | hit;
    end
    return {found, ch};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef TS_QOS_ERR_SAT_EN
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
`else
    return c + CNT_W'(1);
`endif
  endfunction

  logic              fallback_en_q, fallback_en_d;
  logic              manual_en_q, manual_en_d;
  logic [CH_W-1:0]   manual_ch_q, manual_ch_d;
  logic [PW-1:0]     prio_q, prio_d;
  logic [TIMER_W-1:0] holdoff_q, holdoff_d;
  logic [CNT_W-1:0]  err_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  err_cnt_d [NUM_CH];
  state_t            state_q, state_d;
  logic [CH_W-1:0]   active_ch_q, active_ch_d;
  logic              sel_valid_q, sel_valid_d;
  logic              switch_pulse_q, switch_pulse_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] fb_cnt_q, fb_cnt_d;
  logic [CH_W-1:0]   fb_ch_q, fb_ch_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       rd_val;
  logic [CH_W:0]     cand;
  logic [CH_W:0]     alt;
  logic              act_lost;
  logic              act_err;
  logic [TIMER_W-1:0] fb_eff;

  // Register writes; an out-of-range manual channel leaves the stored one untouched.
  always_comb begin
    fallback_en_d = fallback_en_q;
    manual_en_d   = manual_en_q;
    manual_ch_d   = manual_ch_q;
    prio_d        = prio_q;
    holdoff_d     = holdoff_q;
    if (mm.mm_write_en) begin
      case (mm.mm_addr)
        8'h00: begin
          fallback_en_d = mm.mm_wdata[0];
          manual_en_d   = mm.mm_wdata[1];
          manual_ch_d   = (mm.mm_wdata[31:2] < 30'(NUM_CH)) ? mm.mm_wdata[2 +: CH_W] : manual_ch_q;
        end
        8'h01:   prio_d    = mm.mm_wdata[PW-1:0];
        8'h02:   holdoff_d = mm.mm_wdata[TIMER_W-1:0];
        default: holdoff_d = holdoff_q;
      endcase
    end else begin
      holdoff_d = holdoff_q;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (mm.mm_write_en && (mm.mm_addr == 8'(4 + k))) begin
        err_cnt_d[k] = '0;
      end else if (ch_err[k]) begin
        err_cnt_d[k] = cnt_inc(err_cnt_q[k]);
      end else begin
        err_cnt_d[k] = err_cnt_q[k];
      end
    end
  end

  always_comb begin
    rd_val = 32'd0;
    case (mm.mm_addr)
      8'h00:   rd_val = 32'({manual_ch_q, manual_en_q, fallback_en_q});
      8'h01:   rd_val = 32'(prio_q);
      8'h02:   rd_val = 32'(holdoff_q);
      8'h03:   rd_val = 32'({state_q, ch_lock, active_ch_q});
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          rd_val = (mm.mm_addr == 8'(4 + k)) ? 32'(err_cnt_q[k]) : rd_val;
        end
      end
    endcase
    rdata_d = mm.mm_read_en ? rd_val : rdata_q;
  end

  // Selection FSM; decisions use the control values that take effect at this edge.
  always_comb begin
    cand        = pick(prio_d, ch_lock, 1'b0, '0);
    alt         = pick(prio_d, ch_lock, 1'b1, active_ch_q);
    act_lost    = !ch_lock[active_ch_q];
    act_err     = ch_err[active_ch_q];
    fb_eff      = (fb_ch_q == cand[CH_W-1:0]) ? fb_cnt_q : '0;
    state_d     = state_q;
    active_ch_d = active_ch_q;
    timer_d     = timer_q;
    fb_cnt_d    = '0;
    fb_ch_d     = fb_ch_q;
    if (manual_en_d) begin
      state_d     = S_MANUAL;
      active_ch_d = manual_ch_d;
    end else if ((state_q == S_MANUAL) || (state_q == S_NOSIG)) begin
      state_d     = cand[CH_W] ? S_ACTIVE : S_NOSIG;
      active_ch_d = cand[CH_W] ? cand[CH_W-1:0] : active_ch_q;
    end else if (act_lost || ((state_q == S_ACTIVE) && act_err)) begin
      if (alt[CH_W]) begin
        state_d     = S_HOLDOFF;
        active_ch_d = alt[CH_W-1:0];
        timer_d     = holdoff_d;
      end else begin
        state_d     = act_lost ? S_NOSIG : state_q;
      end
    end else if (state_q == S_HOLDOFF) begin
      if (timer_q == '0) begin
        state_d = S_ACTIVE;
      end else begin
        timer_d = timer_q - TIMER_W'(1);
      end
    end else if (fallback_en_d && cand[CH_W] && (cand[CH_W-1:0] != active_ch_q)) begin
      // A better channel must stay locked for holdoff consecutive cycles before we return.
      if (fb_eff >= holdoff_d) begin
        state_d     = S_HOLDOFF;
        active_ch_d = cand[CH_W-1:0];
        timer_d     = holdoff_d;
      end else begin
        fb_cnt_d    = fb_eff + TIMER_W'(1);
        fb_ch_d     = cand[CH_W-1:0];
      end
    end else begin
      state_d = S_ACTIVE;
    end
    sel_valid_d    = (state_d == S_MANUAL) ? ch_lock[manual_ch_d] : (state_d != S_NOSIG);
    switch_pulse_d = (active_ch_d != active_ch_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fallback_en_q  <= 1'b0;
      manual_en_q    <= 1'b0;
      manual_ch_q    <= '0;
      prio_q         <= PRIO_RST;
      holdoff_q      <= TIMER_W'(DEF_TIMER);
      for (int k = 0; k < NUM_CH; k++) err_cnt_q[k] <= '0;
      state_q        <= S_NOSIG;
      active_ch_q    <= '0;
      sel_valid_q    <= 1'b0;
      switch_pulse_q <= 1'b0;
      timer_q        <= '0;
      fb_cnt_q       <= '0;
      fb_ch_q        <= '0;
      rdata_q        <= 32'd0;
    end else begin
      fallback_en_q  <= fallback_en_d;
      manual_en_q    <= manual_en_d;
      manual_ch_q    <= manual_ch_d;
      prio_q         <= prio_d;
      holdoff_q      <= holdoff_d;
      for (int k = 0; k < NUM_CH; k++) err_cnt_q[k] <= err_cnt_d[k];
      state_q        <= state_d;
      active_ch_q    <= active_ch_d;
      sel_valid_q    <= sel_valid_d;
      switch_pulse_q <= switch_pulse_d;
      timer_q        <= timer_d;
      fb_cnt_q       <= fb_cnt_d;
      fb_ch_q        <= fb_ch_d;
      rdata_q        <= rdata_d;
    end
  end

  assign active_ch    = active_ch_q;
  assign sel_valid    = sel_valid_q;
  assign switch_pulse = switch_pulse_q;
  assign mm.mm_rdata  = rdata_q;
endmodule
